conv_mem_responder: RTL and testbench
=====================================

// Module: conv_mem_responder
// PURPOSE
//  Memory-side responder for the CONV engine interface: holds the 64x64 input image, layer-0
//  (4096x20) and layer-1 (1024x20) result memories. Loads the image from a host stream, raises
//  ready to start CONV, serves iaddr/idata and crd/cwr/csel traffic while CONV is busy, then
//  exposes results to the host through a registered read port.
// PARAMETERS
//  IMG_AW  12   image / layer-0 address width (4096 words)
//  L1_AW   10   layer-1 address width (1024 words)
//  DW      20   data width (signed Q4.16)
// PORTS
//  clk       in   1      clock, all state on posedge
//  reset     in   1      asynchronous, active-low reset
//  ld_start  in   1      pulse: restart image load (honoured in IDLE and DONE)
//  ld_valid  in   1      image load word valid
//  ld_data   in   DW     image word, written to image[ld_cnt]
//  ready     out  1      start request to CONV
//  busy      in   1      CONV busy
//  iaddr     in   IMG_AW image read address
//  idata     out  DW     image[iaddr], combinational
//  cwr       in   1      layer write strobe
//  caddr_wr  in   IMG_AW layer write address
//  cdata_wr  in   DW     layer write data
//  crd       in   1      layer read strobe
//  caddr_rd  in   IMG_AW layer read address
//  cdata_rd  out  DW     layer read data, combinational
//  csel      in   3      3'b001 layer 0, 3'b011 layer 1, others none
//  done      out  1      results valid
//  hrd_sel   in   1      host read select: 0 layer 0, 1 layer 1
//  hrd_addr  in   IMG_AW host read address (layer 1 uses [L1_AW-1:0])
//  hrd_data  out  DW     host read data, 1-cycle latency
// BEHAVIOUR
//  Reset: state IDLE, ld_cnt 0, ready 0, done 0, hrd_data 0; memory contents not cleared.
//  FSM: IDLE -> START -> RUN -> DONE.
//   IDLE: each ld_valid cycle writes image[ld_cnt], ld_cnt++ (wraps 4095->0); write of
//    word 4095 -> START. ld_start in IDLE clears ld_cnt (same-cycle ld_valid writes addr 0).
//   START: ready=1 (registered). Sample busy==1 -> RUN, ready=0 next cycle (ready high exactly
//    until the cycle after busy first seen high).
//   RUN: ready=0. busy 1->0 (registered busy_q=1, busy=0) -> DONE, done=1 next cycle.
//   DONE: done=1; ld_start -> IDLE, done=0, ld_cnt=0. ld_valid without ld_start ignored.
//  idata = image[iaddr] every state, async read (CONV samples same cycle).
//  Layer writes: on posedge when cwr=1 and state in {START,RUN}: csel 001 -> L0[caddr_wr];
//   csel 011 -> L1[caddr_wr[L1_AW-1:0]]; other csel or state: ignored.
//  cdata_rd: crd=1 & csel 001 -> L0[caddr_rd]; crd=1 & csel 011 -> L1[caddr_rd[9:0]]; else 0.
//  cwr and crd same cycle, same address: cdata_rd returns pre-write value (write-after-read).
//  Host port: in DONE, hrd_data <= selected layer at hrd_addr next cycle; outside DONE <= 0.
//  No arithmetic; data passes unmodified (bit-exact 20-bit).
//  Reset mid-operation (any state): return to IDLE, ready/done drop immediately; image must be
//   reloaded before next start.
// STRUCTURE
//  Package conv_if_pkg: CSEL_L0=3'b001, CSEL_L1=3'b011, IMG_WORDS=4096, L1_WORDS=1024,
//   DW, state enum {IDLE,START,RUN,DONE}.
//  Sub-module conv_lyr_ram (param AW, DW; sync write, async read) instanced 3x: image, L0, L1.
//  Top holds FSM, ld_cnt, busy_q, write/read decode and host read register.
// TESTING
//  Load 4096 words image[i]=i -> ready rises cycle after 4096th ld_valid; idata at iaddr=63 = 63.
//  START, drive busy=1 at cycle t -> ready=0 at t+1, state RUN; ready never re-asserts in RUN.
//  RUN: cwr csel=001 addr 100 data 20'h1_2345, then crd csel=001 addr 100 -> cdata_rd 20'h1_2345;
//   crd csel=011 addr 100 -> L1 content; csel=010 write -> no memory change.
//  Same-cycle cwr/crd csel=011 addr 5 old 7 new 9 -> cdata_rd 7, next cycle 9.
//  busy falls -> done=1 one cycle later; hrd_sel=1 hrd_addr=1023 -> hrd_data = L1[1023] after 1 clk.
//  Assert reset low in RUN -> ready=0, done=0, state IDLE asynchronously; ld_start in DONE -> IDLE.

Source files
------------

// File: rtl/conv_mem_responder_pkg.sv
// Shared definitions for the CONV memory responder: geometry, layer selects and FSM states.
package conv_if_pkg;

  localparam int IMG_AW    = 12;
  localparam int L1_AW     = 10;
  localparam int DW        = 20;
  localparam int IMG_WORDS = 1 << IMG_AW;
  localparam int L1_WORDS  = 1 << L1_AW;

  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/conv_mem_responder_if.sv
// CONV engine <-> memory responder bus: start handshake, image read, layer read/write.
interface conv_mem_responder_if #(
  parameter int IMG_AW = 12,
  parameter int DW     = 20
);

  logic              ready;
  logic              busy;
  logic [IMG_AW-1:0] iaddr;
  logic [DW-1:0]     idata;
  logic              cwr;
  logic [IMG_AW-1:0] caddr_wr;
  logic [DW-1:0]     cdata_wr;
  logic              crd;
  logic [IMG_AW-1:0] caddr_rd;
  logic [DW-1:0]     cdata_rd;
  logic [2:0]        csel;

  // CONV engine side
  modport master (
    input  ready, idata, cdata_rd,
    output busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );

  // Memory responder side
  modport slave (
    output ready, idata, cdata_rd,
    input  busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );

endinterface

// File: rtl/conv_mem_responder_lyr_ram.sv
// Simple RAM: one synchronous write port, NRD asynchronous read ports.
// A read of the address being written in the same cycle returns the old word.
module conv_lyr_ram #(
  parameter int AW  = 12,
  parameter int DW  = 20,
  parameter int NRD = 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr [NRD],
  output logic [DW-1:0] rdata [NRD]
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];

  // Storage write; contents are deliberately never cleared
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Combinational read ports
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rdata[i] = mem_q[raddr[i]];
    end
  end

endmodule

// File: rtl/conv_mem_responder.sv
// Memory-side responder for the CONV engine: image load from host, start handshake,
// image / layer-0 / layer-1 access during the run, registered host read-back afterwards.
module conv_mem_responder #(
  parameter int IMG_AW = conv_if_pkg::IMG_AW,
  parameter int L1_AW  = conv_if_pkg::L1_AW,
  parameter int DW     = conv_if_pkg::DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_start,
  input  logic                 ld_valid,
  input  logic [DW-1:0]        ld_data,
  output logic                 done,
  input  logic                 hrd_sel,
  input  logic [IMG_AW-1:0]    hrd_addr,
  output logic [DW-1:0]        hrd_data,
  conv_mem_responder_if.slave  cif
);

  import conv_if_pkg::*;

  state_t            state_q, state_d;
  logic [IMG_AW-1:0] ld_cnt_q, ld_cnt_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [DW-1:0]     hrd_data_q, hrd_data_d;

  logic              img_we;
  logic [IMG_AW-1:0] img_waddr;
  logic              lyr_wr_ok;
  logic              l0_we, l1_we;

  logic [IMG_AW-1:0] img_raddr [1];
  logic [DW-1:0]     img_rdata [1];
  logic [IMG_AW-1:0] l0_raddr  [2];
  logic [DW-1:0]     l0_rdata  [2];
  logic [L1_AW-1:0]  l1_raddr  [2];
  logic [DW-1:0]     l1_rdata  [2];

  // Control registers; memories are outside the reset domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ld_cnt_q   <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      hrd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      hrd_data_q <= hrd_data_d;
    end
  end

  // Next state, image load counter and registered ready/done flags
  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    img_we    = 1'b0;
    img_waddr = ld_cnt_q;
    busy_d    = cif.busy;
    case (state_q)
      IDLE: begin
        // A restart pulse aims the same-cycle word at address 0
        if (ld_start) begin
          img_waddr = '0;
          ld_cnt_d  = '0;
        end
        if (ld_valid) begin
          img_we   = 1'b1;
          ld_cnt_d = img_waddr + IMG_AW'(1);
          if (&img_waddr) begin
            state_d = START;
          end
        end
      end
      START: begin
        if (cif.busy) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Falling edge of busy marks the end of the CONV run
        if (busy_q && !cif.busy) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (ld_start) begin
          state_d  = IDLE;
          ld_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == START);
    done_d  = (state_d == DONE);
  end

  // Layer access decode and host read-back mux
  always_comb begin
    lyr_wr_ok    = cif.cwr && ((state_q == START) || (state_q == RUN));
    l0_we        = lyr_wr_ok && (cif.csel == CSEL_L0);
    l1_we        = lyr_wr_ok && (cif.csel == CSEL_L1);
    img_raddr[0] = cif.iaddr;
    l0_raddr[0]  = cif.caddr_rd;
    l0_raddr[1]  = hrd_addr;
    l1_raddr[0]  = cif.caddr_rd[L1_AW-1:0];
    l1_raddr[1]  = hrd_addr[L1_AW-1:0];
    cif.cdata_rd = '0;
    if (cif.crd && (cif.csel == CSEL_L0)) begin
      cif.cdata_rd = l0_rdata[0];
    end else if (cif.crd && (cif.csel == CSEL_L1)) begin
      cif.cdata_rd = l1_rdata[0];
    end
    hrd_data_d = '0;
    if (state_q == DONE) begin
      hrd_data_d = hrd_sel ? l1_rdata[1] : l0_rdata[1];
    end
  end

  assign cif.idata = img_rdata[0];
  assign cif.ready = ready_q;
  assign done      = done_q;
  assign hrd_data  = hrd_data_q;

  conv_lyr_ram #(.AW(IMG_AW), .DW(DW), .NRD(1)) u_img (
    .clk   (clk),
    .we    (img_we),
    .waddr (img_waddr),
    .wdata (ld_data),
    .raddr (img_raddr),
    .rdata (img_rdata)
  );

  conv_lyr_ram #(.AW(IMG_AW), .DW(DW), .NRD(2)) u_l0 (
    .clk   (clk),
    .we    (l0_we),
    .waddr (cif.caddr_wr),
    .wdata (cif.cdata_wr),
    .raddr (l0_raddr),
    .rdata (l0_rdata)
  );

  conv_lyr_ram #(.AW(L1_AW), .DW(DW), .NRD(2)) u_l1 (
    .clk   (clk),
    .we    (l1_we),
    .waddr (cif.caddr_wr[L1_AW-1:0]),
    .wdata (cif.cdata_wr),
    .raddr (l1_raddr),
    .rdata (l1_rdata)
  );

endmodule

// File: tb/tb_conv_mem_responder.sv
// Randomized bench for conv_mem_responder with a behavioural memory/phase model.
module tb_conv_mem_responder;

  localparam int P_IDLE = 0, P_START = 1, P_RUN = 2, P_DONE = 3;

  logic        clk, reset, ld_start, ld_valid, done, hrd_sel;
  logic [19:0] ld_data, hrd_data;
  logic [11:0] hrd_addr;

  conv_mem_responder_if #(.IMG_AW(12), .DW(20)) cif();

  conv_mem_responder dut (
    .clk      (clk),
    .reset    (reset),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .done     (done),
    .hrd_sel  (hrd_sel),
    .hrd_addr (hrd_addr),
    .hrd_data (hrd_data),
    .cif      (cif)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model: memories with known-flags, phase, expected registered outputs
  logic [19:0] m_img [4096];
  bit          k_img [4096];
  logic [19:0] m_l0  [4096];
  bit          k_l0  [4096];
  logic [19:0] m_l1  [1024];
  bit          k_l1  [1024];
  int          m_phase, m_ld;
  bit          m_pbusy, m_ready, m_done, m_hrd_k;
  logic [19:0] m_hrd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 2))
      0:       return 12'($urandom_range(0, 63));
      1:       return 12'(1024 + $urandom_range(0, 63));
      default: return 12'(2048 + $urandom_range(0, 63));
    endcase
  endfunction

  function automatic logic [2:0] pick_csel();
    case ($urandom_range(0, 5))
      0, 1:    return 3'b001;
      2, 3:    return 3'b011;
      4:       return 3'b010;
      default: return 3'($urandom);
    endcase
  endfunction

  task automatic bus_idle();
    cif.cwr = 1'b0; cif.crd = 1'b0; cif.csel = 3'b000;
    cif.caddr_wr = '0; cif.caddr_rd = '0; cif.cdata_wr = '0;
  endtask

  // Model update on each clock edge, or immediately on reset assertion
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = P_IDLE; m_ld = 0; m_pbusy = 0;
      m_ready = 0; m_done = 0; m_hrd = '0; m_hrd_k = 1;
    end else begin
      if (m_phase == P_DONE) begin
        if (hrd_sel) begin
          m_hrd = m_l1[int'(hrd_addr) % 1024]; m_hrd_k = k_l1[int'(hrd_addr) % 1024];
        end else begin
          m_hrd = m_l0[hrd_addr]; m_hrd_k = k_l0[hrd_addr];
        end
      end else begin
        m_hrd = '0; m_hrd_k = 1;
      end
      if (cif.cwr && (m_phase == P_START || m_phase == P_RUN)) begin
        if (cif.csel == 3'b001) begin
          m_l0[cif.caddr_wr] = cif.cdata_wr; k_l0[cif.caddr_wr] = 1;
        end else if (cif.csel == 3'b011) begin
          m_l1[int'(cif.caddr_wr) % 1024] = cif.cdata_wr; k_l1[int'(cif.caddr_wr) % 1024] = 1;
        end
      end
      case (m_phase)
        P_IDLE: begin
          if (ld_start) m_ld = 0;
          if (ld_valid) begin
            m_img[m_ld] = ld_data; k_img[m_ld] = 1;
            m_ld = m_ld + 1;
            if (m_ld == 4096) begin m_ld = 0; m_phase = P_START; end
          end
        end
        P_START: if (cif.busy) m_phase = P_RUN;
        P_RUN:   if (m_pbusy && !cif.busy) m_phase = P_DONE;
        default: if (ld_start) begin m_phase = P_IDLE; m_ld = 0; end
      endcase
      m_pbusy = cif.busy;
      m_ready = (m_phase == P_START);
      m_done  = (m_phase == P_DONE);
    end
  end

  // Compare all outputs against the model away from the active edge
  always @(negedge clk) begin : cmp
    logic [19:0] e;
    bit k;
    check("ready", {31'b0, cif.ready}, {31'b0, m_ready});
    check("done", {31'b0, done}, {31'b0, m_done});
    if (m_hrd_k) check("hrd_data", {12'b0, hrd_data}, {12'b0, m_hrd});
    if (k_img[cif.iaddr]) check("idata", {12'b0, cif.idata}, {12'b0, m_img[cif.iaddr]});
    e = '0; k = 1;
    if (cif.crd && cif.csel == 3'b001) begin
      e = m_l0[cif.caddr_rd]; k = k_l0[cif.caddr_rd];
    end else if (cif.crd && cif.csel == 3'b011) begin
      e = m_l1[int'(cif.caddr_rd) % 1024]; k = k_l1[int'(cif.caddr_rd) % 1024];
    end
    if (k) check("cdata_rd", {12'b0, cif.cdata_rd}, {12'b0, e});
  end

  // Full image load; optional random data, valid gaps and a mid-load restart
  task automatic load_image(input bit rnd, input bit gaps, input int restart_at);
    int n;
    bit restarted;
    n = 0; restarted = 0;
    ld_start = 1; ld_valid = 0; tick(); ld_start = 0;
    while (n < 4096) begin
      cif.cwr = 1'($urandom); cif.crd = 1'($urandom); cif.csel = 3'b001;
      cif.caddr_wr = pick_addr(); cif.caddr_rd = pick_addr(); cif.cdata_wr = 20'($urandom);
      cif.iaddr = 12'($urandom);
      if (gaps && $urandom_range(0, 3) == 0) begin
        ld_valid = 0;
      end else begin
        ld_valid = 1;
        if (!restarted && n == restart_at) begin
          ld_start = 1; n = 0; restarted = 1;
        end
        ld_data = rnd ? 20'($urandom) : 20'(n);
        n++;
        if (n == 4096) check("ready_pre_last", {31'b0, cif.ready}, 32'd0);
      end
      tick();
      ld_start = 0;
    end
    ld_valid = 0;
    bus_idle();
  endtask

  task automatic conv_traffic(input int cycles);
    repeat (cycles) begin
      cif.cwr = 1'($urandom); cif.crd = 1'($urandom); cif.csel = pick_csel();
      cif.caddr_wr = pick_addr(); cif.caddr_rd = pick_addr(); cif.cdata_wr = 20'($urandom);
      cif.iaddr = 12'($urandom);
      tick();
    end
    bus_idle();
  endtask

  task automatic host_reads(input int cycles);
    repeat (cycles) begin
      hrd_sel = 1'($urandom); hrd_addr = pick_addr();
      ld_valid = 1'($urandom); ld_data = 20'($urandom);
      cif.iaddr = 12'($urandom);
      tick();
    end
    ld_valid = 0;
  endtask

  task automatic async_reset_pulse();
    @(posedge clk); #3;
    reset = 0;
    #1;
    check("rst_async_ready", {31'b0, cif.ready}, 32'd0);
    check("rst_async_done", {31'b0, done}, 32'd0);
    check("rst_async_hrd", {12'b0, hrd_data}, 32'd0);
    cif.busy = 0; bus_idle();
    @(negedge clk); #1;
    reset = 1;
    tick();
  endtask

  initial begin
    reset = 0; ld_start = 0; ld_valid = 0; ld_data = '0;
    hrd_sel = 0; hrd_addr = '0; cif.busy = 0; cif.iaddr = '0;
    bus_idle();
    #12;
    check("reset_ready", {31'b0, cif.ready}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_hrd", {12'b0, hrd_data}, 32'd0);
    @(negedge clk); reset = 1;

    // Run 1: ramp image, directed layer traffic, host read-back
    load_image(0, 0, -1);
    check("ready_after_load", {31'b0, cif.ready}, 32'd1);
    cif.iaddr = 12'd63; #1;
    check("idata_63", {12'b0, cif.idata}, 32'd63);
    tick(); tick();
    check("ready_hold", {31'b0, cif.ready}, 32'd1);
    cif.busy = 1; #1;
    check("ready_at_busy", {31'b0, cif.ready}, 32'd1);
    tick();
    check("ready_after_busy", {31'b0, cif.ready}, 32'd0);

    cif.cwr = 1; cif.csel = 3'b001; cif.caddr_wr = 12'd100; cif.cdata_wr = 20'h12345; tick();
    cif.csel = 3'b011; cif.cdata_wr = 20'h0ABCD; tick();
    cif.csel = 3'b010; cif.cdata_wr = 20'hFFFFF; tick();
    cif.cwr = 0; cif.crd = 1; cif.csel = 3'b001; cif.caddr_rd = 12'd100; #1;
    check("rd_l0_100", {12'b0, cif.cdata_rd}, 32'h12345); tick();
    cif.csel = 3'b011; #1;
    check("rd_l1_100", {12'b0, cif.cdata_rd}, 32'h0ABCD); tick();
    cif.csel = 3'b010; #1;
    check("rd_csel_none", {12'b0, cif.cdata_rd}, 32'd0); tick();
    cif.crd = 0; cif.csel = 3'b001; #1;
    check("rd_crd_off", {12'b0, cif.cdata_rd}, 32'd0); tick();

    cif.cwr = 1; cif.csel = 3'b011; cif.caddr_wr = 12'd5; cif.cdata_wr = 20'd7; tick();
    cif.crd = 1; cif.caddr_rd = 12'd5; cif.cdata_wr = 20'd9; #1;
    check("war_old", {12'b0, cif.cdata_rd}, 32'd7); tick();
    cif.cwr = 0; #1;
    check("war_new", {12'b0, cif.cdata_rd}, 32'd9); tick();
    bus_idle();

    conv_traffic(300);
    check("ready_in_run", {31'b0, cif.ready}, 32'd0);
    cif.cwr = 1; cif.csel = 3'b011; cif.caddr_wr = 12'd1023; cif.cdata_wr = 20'hABCDE; tick();
    bus_idle();

    cif.busy = 0; #1;
    check("done_pre", {31'b0, done}, 32'd0);
    tick();
    check("done_rise", {31'b0, done}, 32'd1);
    hrd_sel = 1; hrd_addr = 12'd1023; tick();
    check("hrd_l1_1023", {12'b0, hrd_data}, 32'hABCDE);
    hrd_sel = 0; hrd_addr = 12'd100; tick();
    check("hrd_l0_100", {12'b0, hrd_data}, 32'h12345);
    host_reads(40);
    check("done_hold", {31'b0, done}, 32'd1);
    ld_start = 1; tick(); ld_start = 0;
    check("done_clear", {31'b0, done}, 32'd0);
    tick();
    check("hrd_idle_zero", {12'b0, hrd_data}, 32'd0);

    // Run 2: random image with gaps and a restart; reset while ready is high
    load_image(1, 1, 100);
    check("ready_load2", {31'b0, cif.ready}, 32'd1);
    tick();
    async_reset_pulse();
    repeat (3) tick();

    // Run 3: reset while done is high
    load_image(1, 0, -1);
    cif.busy = 1; tick();
    conv_traffic(30);
    cif.busy = 0; tick();
    check("done_run3", {31'b0, done}, 32'd1);
    host_reads(20);
    async_reset_pulse();

    // Run 4: reset in RUN, then the counter restarts from address 0
    load_image(1, 0, -1);
    cif.busy = 1; tick();
    conv_traffic(20);
    async_reset_pulse();
    ld_valid = 1; ld_data = 20'h77777; tick(); ld_valid = 0;
    cif.iaddr = 12'd0; #1;
    check("idle_after_reset", {12'b0, cif.idata}, 32'h77777);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
